// File: rtl/barrel_pkg.sv
// Shared constants, types and helpers for the barrel-projection coordinate path.
package barrel_pkg;

    // Width of every pixel coordinate carried through the path (up to 4096 pixels).
    localparam int COORD_W = 12;

    // Signed width for the dx*w*RECIP product.
    // Sized with headroom for the largest 4096x4096 frame.
    localparam int PROD_W = 40;

    typedef logic signed [PROD_W-1:0] prod_t;

    // Q16 reciprocal of the frame height.
    // It replaces the per-pixel divide by a multiply and a shift.
    function automatic int calcRecip(input int height);
        return 65536 / height;
    endfunction

endpackage

// File: rtl/barrel_coord_map.sv
// Three-stage barrel mapping pipeline.
// It turns a raster position (x, y) into the source coordinate
// (cx + floor(dx*w*RECIP / 2^16), y), clamped to the frame.
module barrel_coord_map
    import barrel_pkg::*;
#(
    parameter int WIDTH  = 1080,
    parameter int HEIGHT = 960
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               valid_i,
    input  logic [COORD_W-1:0] x_i,
    input  logic [COORD_W-1:0] y_i,
    output logic               valid_o,
    output logic [COORD_W-1:0] mathX_o,
    output logic [COORD_W-1:0] mathY_o
);

    localparam prod_t CX_P     = prod_t'(WIDTH / 2);
    localparam prod_t CY_P     = prod_t'(HEIGHT / 2);
    localparam prod_t HEIGHT_P = prod_t'(HEIGHT);
    localparam prod_t RECIP_P  = prod_t'(calcRecip(HEIGHT));
    localparam prod_t XMAX_P   = prod_t'(WIDTH - 1);

    logic               s1Valid_q;
    logic [COORD_W-1:0] s1X_q;
    logic [COORD_W-1:0] s1Y_q;

    prod_t              yDiff;
    prod_t              dy;
    prod_t              w;
    prod_t              dxw_d;
    logic               s2Valid_q;
    prod_t              s2Dxw_q;
    logic [COORD_W-1:0] s2Y_q;

    prod_t              scaled;
    prod_t              mapped;
    logic [COORD_W-1:0] mathX_d;
    logic               valid_q;
    logic [COORD_W-1:0] mathX_q;
    logic [COORD_W-1:0] mathY_q;

    // Stage 1: register the incoming raster position and its valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1Valid_q <= 1'b0;
            s1X_q     <= '0;
            s1Y_q     <= '0;
        end else begin
            s1Valid_q <= valid_i;
            s1X_q     <= x_i;
            s1Y_q     <= y_i;
        end
    end

    // Stage 2 datapath: compute the distance from the centre row and the row weight w.
    always_comb begin
        yDiff = prod_t'(s1Y_q) - CY_P;
        dy    = (yDiff < prod_t'(0)) ? -yDiff : yDiff;
        w     = HEIGHT_P - dy;
        dxw_d = (prod_t'(s1X_q) - CX_P) * w;
    end

    // Stage 2 register: hold the signed dx*w product alongside the row.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s2Valid_q <= 1'b0;
            s2Dxw_q   <= '0;
            s2Y_q     <= '0;
        end else begin
            s2Valid_q <= s1Valid_q;
            s2Dxw_q   <= dxw_d;
            s2Y_q     <= s1Y_q;
        end
    end

    // Stage 3 datapath: scale by RECIP, floor-shift, recentre and clamp into the frame.
    always_comb begin
        scaled = s2Dxw_q * RECIP_P;
        mapped = CX_P + (scaled >>> 16);
        if (mapped < prod_t'(0)) begin
            mapped = prod_t'(0);
        end else if (mapped > XMAX_P) begin
            mapped = XMAX_P;
        end
        mathX_d = COORD_W'(mapped);
    end

    // Stage 3 register: publish one result per beat; coordinates hold between beats.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= 1'b0;
            mathX_q <= '0;
            mathY_q <= '0;
        end else begin
            valid_q <= s2Valid_q;
            if (s2Valid_q) begin
                mathX_q <= mathX_d;
                mathY_q <= s2Y_q;
            end
        end
    end

    assign valid_o = valid_q;
    assign mathX_o = mathX_q;
    assign mathY_o = mathY_q;

endmodule

// File: rtl/barrel_projection_wrapper.sv
// Stream front end of the barrel-projection path.
// It accepts raster pixels, tracks (x, y) and feeds the mapping pipeline.
module barrel_projection_wrapper
    import barrel_pkg::*;
#(
    parameter int WIDTH  = 1080,
    parameter int HEIGHT = 960
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [15:0]        AXIS_IN_tdata,
    input  logic               AXIS_IN_tvalid,
    output logic               AXIS_IN_tready,
    output logic               Math_Valid,
    output logic [COORD_W-1:0] MathX,
    output logic [COORD_W-1:0] MathY
);

    localparam logic [COORD_W-1:0] X_LAST = COORD_W'(WIDTH - 1);
    localparam logic [COORD_W-1:0] Y_LAST = COORD_W'(HEIGHT - 1);
    localparam logic [COORD_W-1:0] ONE    = COORD_W'(1);

    logic               ready_q;
    logic               accept;
    logic [COORD_W-1:0] x_q;
    logic [COORD_W-1:0] x_d;
    logic [COORD_W-1:0] y_q;
    logic [COORD_W-1:0] y_d;
    logic               beatValid_q;
    logic [COORD_W-1:0] beatX_q;
    logic [COORD_W-1:0] beatY_q;
    logic               unusedTdata;

    // Pixel payload is not used by the coordinate path in this revision.
    assign unusedTdata = ^AXIS_IN_tdata;
    assign accept      = AXIS_IN_tvalid & ready_q;

    // Ready rises on the first clock after reset and never applies backpressure.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ready_q <= 1'b0;
        end else begin
            ready_q <= 1'b1;
        end
    end

    // Next raster position: x wraps at the line end and carries into y, which wraps at the frame end.
    always_comb begin
        x_d = x_q;
        y_d = y_q;
        if (accept) begin
            if (x_q == X_LAST) begin
                x_d = '0;
                y_d = (y_q == Y_LAST) ? '0 : y_q + ONE;
            end else begin
                x_d = x_q + ONE;
            end
        end
    end

    // Raster counter registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            x_q <= '0;
            y_q <= '0;
        end else begin
            x_q <= x_d;
            y_q <= y_d;
        end
    end

    // Capture the accepted beat's position at the stream boundary before it enters the mapper.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            beatValid_q <= 1'b0;
            beatX_q     <= '0;
            beatY_q     <= '0;
        end else begin
            beatValid_q <= accept;
            if (accept) begin
                beatX_q <= x_q;
                beatY_q <= y_q;
            end
        end
    end

    barrel_coord_map #(
        .WIDTH  (WIDTH),
        .HEIGHT (HEIGHT)
    ) u_coordMap (
        .clk     (clk),
        .reset   (reset),
        .valid_i (beatValid_q),
        .x_i     (beatX_q),
        .y_i     (beatY_q),
        .valid_o (Math_Valid),
        .mathX_o (MathX),
        .mathY_o (MathY)
    );

    assign AXIS_IN_tready = ready_q;

endmodule

// File: tb/tb_barrel_projection_wrapper.sv
// Self-checking bench for barrel_projection_wrapper.
// Instance A uses the 1080x960 frame.
// Instance B uses a tiny 8x6 frame so that full-frame wrap and the centre row are reached quickly.
module tb_barrel_projection_wrapper;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        tvalid = 1'b0;
    logic [15:0] tdata = 16'h0;

    logic        readyA, validA, readyB, validB;
    logic [11:0] xA, yA, xB, yB;

    int assertCount = 0;
    int failCount   = 0;

    int W [2];
    int H [2];
    int rx [2];
    int ry [2];
    int beatIdx [2];
    int accCount [2];
    int validCount [2];
    int lastX [2];
    int lastY [2];
    bit pV [2][4];
    int pX [2][4];
    int pY [2][4];
    int pI [2][4];

    always #5 clk = ~clk;

    barrel_projection_wrapper dutA (
        .clk            (clk),
        .reset          (reset),
        .AXIS_IN_tdata  (tdata),
        .AXIS_IN_tvalid (tvalid),
        .AXIS_IN_tready (readyA),
        .Math_Valid     (validA),
        .MathX          (xA),
        .MathY          (yA)
    );

    barrel_projection_wrapper #(.WIDTH(8), .HEIGHT(6)) dutB (
        .clk            (clk),
        .reset          (reset),
        .AXIS_IN_tdata  (tdata),
        .AXIS_IN_tvalid (tvalid),
        .AXIS_IN_tready (readyB),
        .Math_Valid     (validB),
        .MathX          (xB),
        .MathY          (yB)
    );

    // Counts every comparison and reports any mismatch.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        assertCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Reference barrel mapping, computed from the mapping formula.
    function automatic int refMathX(input int x, input int y, input int w, input int h);
        longint cx, cy, recip, dx, dy, ww, p, s;
        cx = w / 2;
        cy = h / 2;
        recip = 65536 / h;
        dx = x - cx;
        dy = (y > cy) ? y - cy : cy - y;
        ww = h - dy;
        p = (dx * ww * recip) >>> 16;
        s = cx + p;
        if (s < 0) s = 0;
        if (s > w - 1) s = w - 1;
        return int'(s);
    endfunction

    // Hand-computed expectations for selected beats.
    // Each entry gives the beat index, the expected MathX and the expected MathY.
    task automatic directedCheck(input int k, input int idx, input logic [11:0] obsX, input logic [11:0] obsY);
        int ex, ey;
        bit hit;
        hit = 1'b1;
        ex = 0;
        ey = 0;
        if (k == 0) begin
            case (idx)
                0:       begin ex = 271;  ey = 0; end
                540:     begin ex = 540;  ey = 0; end
                1079:    begin ex = 808;  ey = 0; end
                1080:    begin ex = 270;  ey = 1; end
                default: hit = 1'b0;
            endcase
        end else begin
            case (idx)
                0:       begin ex = 2; ey = 0; end
                24:      begin ex = 0; ey = 3; end
                31:      begin ex = 6; ey = 3; end
                47:      begin ex = 5; ey = 5; end
                48:      begin ex = 2; ey = 0; end
                default: hit = 1'b0;
            endcase
        end
        if (hit) begin
            checkOutput($sformatf("dir%0d_beat%0d_x", k, idx), 32'(obsX), 32'(ex));
            checkOutput($sformatf("dir%0d_beat%0d_y", k, idx), 32'(obsY), 32'(ey));
        end
    endtask

    // Clears the reference state to match a freshly reset DUT.
    task automatic resetModel();
        for (int k = 0; k < 2; k++) begin
            rx[k] = 0;
            ry[k] = 0;
            beatIdx[k] = 0;
            accCount[k] = 0;
            validCount[k] = 0;
            lastX[k] = 0;
            lastY[k] = 0;
            for (int s = 0; s < 4; s++) begin
                pV[k][s] = 1'b0;
                pX[k][s] = 0;
                pY[k][s] = 0;
                pI[k][s] = 0;
            end
        end
    endtask

    // One clock of stimulus, entered and left on a falling edge.
    // It drives tvalid, predicts acceptance and checks the outputs after the next rising edge.
    task automatic applyStimulus(input logic v);
        logic obsV;
        logic [11:0] obsX, obsY;
        bit acc;
        tvalid = v;
        tdata = 16'($urandom);
        for (int k = 0; k < 2; k++) begin
            for (int s = 3; s > 0; s--) begin
                pV[k][s] = pV[k][s-1];
                pX[k][s] = pX[k][s-1];
                pY[k][s] = pY[k][s-1];
                pI[k][s] = pI[k][s-1];
            end
            acc = v && ((k == 0) ? readyA : readyB);
            pV[k][0] = acc;
            if (acc) begin
                pX[k][0] = refMathX(rx[k], ry[k], W[k], H[k]);
                pY[k][0] = ry[k];
                pI[k][0] = beatIdx[k];
                beatIdx[k]++;
                accCount[k]++;
                rx[k]++;
                if (rx[k] == W[k]) begin
                    rx[k] = 0;
                    ry[k]++;
                    if (ry[k] == H[k]) ry[k] = 0;
                end
            end
        end
        @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            obsV = (k == 0) ? validA : validB;
            obsX = (k == 0) ? xA : xB;
            obsY = (k == 0) ? yA : yB;
            checkOutput($sformatf("valid%0d", k), 32'(obsV), 32'(pV[k][3]));
            if (pV[k][3]) begin
                validCount[k]++;
                lastX[k] = pX[k][3];
                lastY[k] = pY[k][3];
                directedCheck(k, pI[k][3], obsX, obsY);
            end
            if (obsV) validCount[k] += 0;
            checkOutput($sformatf("mathX%0d", k), 32'(obsX), 32'(lastX[k]));
            checkOutput($sformatf("mathY%0d", k), 32'(obsY), 32'(lastY[k]));
        end
    endtask

    initial begin
        int guard;
        W[0] = 1080; H[0] = 960;
        W[1] = 8;    H[1] = 6;
        resetModel();

        // Reset held low for 100 ns.
        reset = 1'b0;
        tvalid = 1'b0;
        #103;
        checkOutput("rst_tready", 32'(readyA), 32'd0);
        checkOutput("rst_valid", 32'(validA), 32'd0);
        checkOutput("rst_mathX", 32'(xA), 32'd0);
        checkOutput("rst_mathY", 32'(yA), 32'd0);
        @(negedge clk);
        reset = 1'b1;
        #1;
        checkOutput("tready_before_edge", 32'(readyA), 32'd0);
        @(posedge clk);
        #1;
        checkOutput("tready_after_edge", 32'(readyA), 32'd1);
        @(negedge clk);

        // Continuous stream through the first line and into the second.
        repeat (1200) applyStimulus(1'b1);

        // Pseudo-random gaps in tvalid; every accepted beat must yield exactly one result.
        repeat (3000) applyStimulus(1'($urandom_range(0, 1)));
        repeat (5) applyStimulus(1'b0);
        checkOutput("gap_count0", 32'(validCount[0]), 32'(accCount[0]));
        checkOutput("gap_count1", 32'(validCount[1]), 32'(accCount[1]));

        // Run up to beat 5000, with a bounded number of cycles.
        guard = 0;
        while (beatIdx[0] < 5000 && guard < 10000) begin
            applyStimulus(1'b1);
            guard++;
        end
        checkOutput("reach_beat5000", 32'(beatIdx[0]), 32'd5000);

        // Mid-frame reset: the outputs must clear at once, without waiting for a clock edge.
        #2;
        reset = 1'b0;
        #1;
        checkOutput("midrst_valid0", 32'(validA), 32'd0);
        checkOutput("midrst_valid1", 32'(validB), 32'd0);
        checkOutput("midrst_tready", 32'(readyA), 32'd0);
        checkOutput("midrst_mathX", 32'(xA), 32'd0);
        resetModel();
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;

        // After release, the results restart from (0,0).
        repeat (120) applyStimulus(1'b1);
        repeat (5) applyStimulus(1'b0);
        checkOutput("post_count0", 32'(validCount[0]), 32'(accCount[0]));
        checkOutput("post_count1", 32'(validCount[1]), 32'(accCount[1]));

        $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
        $finish;
    end

endmodule
